manchester_frame_packer: RTL and testbench
==========================================

# manchester_frame_packer

Receive-side frame packer sitting directly downstream of the Manchester decoder. It consumes the decoder's byte stream (`decoded_byte`/`byte_valid`, one frame of FRAME_SIZE bytes per detected preamble) and groups the bytes into fixed-size frames. It optionally checks a trailing CRC-8, buffers complete frames in an internal FIFO, and presents only good, complete frames on an AXI4-Stream master with `tlast`. The decoder cannot be stalled, so overflow, bad-CRC and stalled frames are dropped whole and counted.

## Interface
- FRAME_SIZE, 6, bytes per frame as emitted by the decoder, including the CRC byte when enabled; valid range 2..16.
- FIFO_DEPTH, 32, payload bytes of storage; must be a power of two and at least the payload length.
- GAP_TIMEOUT, 64, maximum number of idle cycles allowed between two bytes of the same frame.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- byte_in  in  8  decoded byte from the decoder.
- byte_in_valid  in  1  one-cycle strobe qualifying byte_in; there is no ready back to the decoder.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last payload byte of a frame.
- frame_count  out  16  frames committed; saturates at 0xFFFF.
- drop_count  out  16  frames dropped (CRC, overflow or timeout); saturates at 0xFFFF.
- crc_err  out  1  one-cycle pulse when a frame is dropped for a CRC mismatch.

## Operation
- Payload length P: P = FRAME_SIZE-1 with FRAME_CRC_EN defined, otherwise P = FRAME_SIZE.
- Write side:
  - An input byte counter `in_idx` runs from 0 to FRAME_SIZE-1.
  - Bytes with in_idx < P are written at `wr_ptr`, and `wr_ptr` increments. `commit_ptr` marks the end of the last committed frame.
- Write-side states:
  - IDLE: in_idx = 0.
  - COLLECT: entered on the first byte of a frame.
  - In COLLECT the gap counter clears on each byte and increments otherwise. When it reaches GAP_TIMEOUT, the block performs a drop and returns to IDLE.
- End of frame, taken on the edge that accepts byte in_idx = FRAME_SIZE-1:
  - Commit when the frame is not flagged and the CRC matches: commit_ptr ← wr_ptr including this edge's write, and frame_count is incremented.
  - Otherwise drop: wr_ptr ← commit_ptr and drop_count is incremented.
  - In both cases in_idx ← 0.
- Overflow:
  - A write when wr_ptr - rd_ptr == FIFO_DEPTH is suppressed, and the frame is flagged.
  - A flagged frame keeps counting bytes and is dropped at its end.
- Pointers are ADDR+1 bits wide, with ADDR = clog2(FIFO_DEPTH), and wrap naturally.
- Read side:
  - Data is available when commit_ptr != rd_ptr.
  - The output register follows standard AXI-S rules: it loads when it is empty or when the current beat transfers (tvalid & tready).
  - tdata, tvalid and tlast stay stable while tvalid is high and tready is low.
  - `out_idx` counts 0..P-1 across transferred beats. tlast = (out_idx == P-1).
- Simultaneous events: a commit and a read in the same cycle are both honoured. The full test uses rd_ptr as it is before this cycle's read.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_count=0, drop_count=0, crc_err=0, all pointers 0, in_idx=0, out_idx=0, state IDLE.
- A reset in mid-frame or with a full FIFO discards all buffered and partial data.
- Latency: with the last byte accepted on edge E and tready held high:
  - the first payload beat has tvalid high after edge E+1;
  - payload beats then stream one per cycle.
- The drop and crc_err pulse are registered on edge E.
- Throughput: the read side sustains 1 byte/cycle, which exceeds the decoder's maximum byte rate.

## Configuration
- FRAME_CRC_EN defined:
  - The last frame byte is a CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR) over the P payload bytes, in the order received.
  - The CRC is accumulated byte-serially on the write side.
  - The CRC byte is compared and never stored.
  - A mismatch causes a drop and a crc_err pulse.
- FRAME_CRC_EN undefined:
  - No CRC logic is built, and all FRAME_SIZE bytes are payload.
  - crc_err is tied to 0.
  - Drops occur only for overflow or timeout.

## Test plan
- FRAME_CRC_EN defined, FRAME_SIZE=6, tready=1:
  - Feed 01 02 03 04 05 followed by the model CRC byte, spaced 8 cycles apart.
  - Required: beats 01..05, tlast on 05, first tvalid 2 edges after the CRC byte, frame_count=1.
- Same frame with the CRC byte XOR 0x01:
  - Required: no beats, crc_err pulses once, drop_count=1, and the next good frame streams normally.
- tready=0 for 500 cycles while good frames keep arriving into FIFO_DEPTH=32 (six frames of 5 bytes fit; the seventh overflows):
  - Required: drop_count=1 and frame_count=6.
  - After tready is released, exactly 30 beats with tlast every 5th beat, contents intact.
- Send 3 bytes of a frame, then idle 64 cycles:
  - Required: drop_count increments and wr_ptr returns to commit_ptr.
  - A following full frame is received correctly, aligned from byte 0.
- Random tready (50%) across 20 frames:
  - Required: tdata, tvalid and tlast are stable whenever tvalid=1 and tready=0.
  - Output equals input payload order.
- Assert aresetn low mid-frame with 2 frames buffered:
  - Required: tvalid=0 immediately (asynchronously) and both counters 0.
  - After reset, the next frame is received correctly.

Source files
------------

// File: rtl/manchester_frame_packer.sv
// manchester_frame_packer
//
// Groups the Manchester decoder's byte stream into fixed-size frames and
// buffers them in a FIFO. Only complete, good frames are presented on an
// AXI4-Stream master, with tlast on the final payload byte. The decoder
// cannot be stalled, so a frame that overflows the FIFO, stalls too long
// between bytes or fails its CRC is dropped whole and counted.
//
// Build option: define FRAME_CRC_EN to treat the last frame byte as a
// CRC-8 (poly 0x07, init 0x00) over the payload. The CRC byte is checked and
// never stored. Without it, every frame byte is payload and crc_err is 0.
//
// Ports:
//   aclk, aresetn      clock (rising edge), async active-low reset
//   byte_in[7:0]       decoded byte, qualified by byte_in_valid (no ready)
//   m_axis_tdata[7:0]  payload byte
//   m_axis_tvalid      beat valid
//   m_axis_tready      downstream ready
//   m_axis_tlast       last payload byte of a frame
//   frame_count[15:0]  frames committed, saturating
//   drop_count[15:0]   frames dropped (CRC, overflow, gap timeout), saturating
//   crc_err            one-cycle pulse on a CRC-mismatch drop
//
// Write-side FSM:
//   state     | meaning
//   S_IDLE    | between frames, in_idx = 0
//   S_COLLECT | inside a frame, gap timer running

module manchester_frame_packer #(
    parameter int FRAME_SIZE  = 6,
    parameter int FIFO_DEPTH  = 32,
    parameter int GAP_TIMEOUT = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic        crc_err
);

`ifdef FRAME_CRC_EN
    localparam int P = FRAME_SIZE - 1;
`else
    localparam int P = FRAME_SIZE;
`endif
    localparam int ADDR = $clog2(FIFO_DEPTH);
    localparam int IW   = $clog2(FRAME_SIZE);
    localparam int GW   = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_t;

    state_t          state_q, state_d;
    logic [ADDR:0]   wr_ptr, commit_ptr, rd_ptr, wr_ptr_inc;
    logic [IW-1:0]   in_idx, out_idx;
    logic [GW-1:0]   gap_cnt;
    logic            ovf_flag;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            last_byte, is_payload, fifo_full, wr_en, ovf_now;
    logic            crc_ok, frame_end, gap_expired, do_commit, do_drop;
    logic            data_avail, out_load;

    assign last_byte = (in_idx == IW'(FRAME_SIZE - 1));
`ifdef FRAME_CRC_EN
    assign is_payload = !last_byte;
`else
    assign is_payload = 1'b1;
`endif
    // Full test uses the read pointer before this cycle's read.
    assign fifo_full  = ((wr_ptr - rd_ptr) == (ADDR+1)'(FIFO_DEPTH));
    assign wr_en      = byte_in_valid && is_payload && !fifo_full;
    assign ovf_now    = byte_in_valid && is_payload && fifo_full;
    assign wr_ptr_inc = wr_ptr + {{ADDR{1'b0}}, wr_en};

`ifdef FRAME_CRC_EN
    logic [7:0] crc_acc;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign crc_ok = (byte_in == crc_acc);
`else
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        frame_end   = 1'b0;
        gap_expired = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (byte_in_valid) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (byte_in_valid) begin
                    if (last_byte) begin
                        frame_end = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (gap_cnt == '0) begin
                    gap_expired = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign do_commit = frame_end && !(ovf_flag || ovf_now) && crc_ok;
    assign do_drop   = (frame_end && !do_commit) || gap_expired;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Gap timer is a down-counter reloaded on every byte; reaching zero on an
    // idle cycle means GAP_TIMEOUT idle cycles have elapsed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            in_idx      <= '0;
            gap_cnt     <= '0;
            ovf_flag    <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
`ifdef FRAME_CRC_EN
            crc_acc     <= '0;
            crc_err     <= 1'b0;
`endif
        end else begin
            if (wr_en) wr_ptr <= wr_ptr_inc;
            if (byte_in_valid) begin
                in_idx  <= in_idx + IW'(1);
                gap_cnt <= GW'(GAP_TIMEOUT - 1);
                if (ovf_now) ovf_flag <= 1'b1;
`ifdef FRAME_CRC_EN
                if (is_payload) crc_acc <= crc8_byte(crc_acc, byte_in);
`endif
            end else if (state_q == S_COLLECT && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            if (do_commit) begin
                commit_ptr <= wr_ptr_inc;
                if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
            end
            if (do_drop) begin
                wr_ptr <= commit_ptr;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            if (frame_end || gap_expired) begin
                in_idx   <= '0;
                ovf_flag <= 1'b0;
`ifdef FRAME_CRC_EN
                crc_acc  <= '0;
`endif
            end
`ifdef FRAME_CRC_EN
            crc_err <= frame_end && !crc_ok;
`endif
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr[ADDR-1:0]] <= byte_in;
    end

    assign data_avail = (commit_ptr != rd_ptr);
    assign out_load   = data_avail && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr        <= '0;
            out_idx       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (out_load) begin
            m_axis_tdata  <= mem[rd_ptr[ADDR-1:0]];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (out_idx == IW'(P - 1));
            out_idx       <= (out_idx == IW'(P - 1)) ? '0 : out_idx + IW'(1);
            rd_ptr        <= rd_ptr + (ADDR+1)'(1);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_manchester_frame_packer.sv
module tb_manchester_frame_packer;

    localparam int FRAME_SIZE  = 6;
    localparam int FIFO_DEPTH  = 32;
    localparam int GAP_TIMEOUT = 64;
`ifdef FRAME_CRC_EN
    localparam int P = FRAME_SIZE - 1;
`else
    localparam int P = FRAME_SIZE;
`endif

    logic        aclk, aresetn;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [15:0] frame_count, drop_count;
    logic        crc_err;

    manchester_frame_packer #(
        .FRAME_SIZE (FRAME_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .byte_in      (byte_in),
        .byte_in_valid(byte_in_valid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .frame_count  (frame_count),
        .drop_count   (drop_count),
        .crc_err      (crc_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_vec = 0, n_fail = 0;
    logic [8:0]  exp_q [$];
    int          exp_frames = 0, exp_drops = 0, exp_crc = 0;
    int          beats = 0, crc_pulses = 0, cyc = 0;
    int          rdy_mode = 0;
    bit          stall_prev = 0;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic [7:0]  pl [16];

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // CRC-8, poly x^8+x^2+x+1, MSB-first bit-serial long division.
    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: every transferred beat against the model queue, and
    // hold-stability whenever the previous sample was valid-but-stalled.
    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            stall_prev = 0;
        end else begin
            if (crc_err) crc_pulses++;
            if (stall_prev) begin
                n_vec++;
                if (!(m_axis_tvalid && m_axis_tdata == hold_data && m_axis_tlast == hold_last)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=0x%0h l=%0b, expected v=1 d=0x%0h l=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, hold_data, hold_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_vec++;
                beats++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got d=0x%0h l=%0b, expected no beat",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e[7:0] || m_axis_tlast !== e[8]) begin
                        n_fail++;
                        $display("FAIL beat_data: got d=0x%0h l=%0b, expected d=0x%0h l=%0b",
                                 m_axis_tdata, m_axis_tlast, e[7:0], e[8]);
                    end
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            hold_data  = m_axis_tdata;
            hold_last  = m_axis_tlast;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int idle);
        repeat (idle) @(posedge aclk);
        #1;
        byte_in       = b;
        byte_in_valid = 1'b1;
        @(posedge aclk);
        #1;
        byte_in_valid = 1'b0;
    endtask

    // Sends one frame and updates the model. Capacity rule: the FIFO plus the
    // output register hold FIFO_DEPTH+1 bytes once something is presented.
    task automatic send_frame(input bit corrupt, input int spacing);
        logic [7:0] c;
        bit         fits;
        c    = 8'h00;
        fits = (exp_q.size() == 0) || (exp_q.size() + P <= FIFO_DEPTH + 1);
        for (int i = 0; i < P; i++) begin
            send_byte(pl[i], spacing);
            c = crc8_upd(c, pl[i]);
        end
`ifdef FRAME_CRC_EN
        send_byte(c ^ {7'd0, corrupt}, spacing);
        if (corrupt) exp_crc++;
`endif
        if (fits && !corrupt) begin
            for (int i = 0; i < P; i++) exp_q.push_back({(i == P - 1), pl[i]});
            exp_frames++;
        end else begin
            exp_drops++;
        end
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < max_cyc) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_drain_left"}, exp_q.size() + int'(m_axis_tvalid), 0);
    endtask

    task automatic check_counts(input string name);
        check({name, "_frames"}, frame_count, exp_frames);
        check({name, "_drops"}, drop_count, exp_drops);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int t0, b0, f0, d0;
        aresetn       = 1'b0;
        byte_in       = 8'h00;
        byte_in_valid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_frames", frame_count, 0);
        check("rst_drops", drop_count, 0);
        check("rst_crc_err", crc_err, 0);
        #1 aresetn = 1'b1;

        // Frame 01 02 03 .. with literal CRC, tready high: latency and contents
        rdy_mode = 1;
        for (int i = 0; i < P; i++) send_byte(8'(i + 1), 8);
`ifdef FRAME_CRC_EN
        send_byte(8'hBC, 8);
`endif
        for (int i = 0; i < P; i++) exp_q.push_back({(i == P - 1), 8'(i + 1)});
        exp_frames++;
        @(negedge aclk);
        check("lat_e0_tvalid", m_axis_tvalid, 0);
        @(negedge aclk);
        check("lat_e1_tvalid", m_axis_tvalid, 1);
        check("lat_e1_tdata", m_axis_tdata, 8'h01);
        wait_drain(50, "t1");
        check("t1_frames_lit", frame_count, 1);
        check("t1_beats_lit", beats, P);

`ifdef FRAME_CRC_EN
        // Same frame, CRC byte flipped in bit 0: dropped with a crc_err pulse
        for (int i = 0; i < P; i++) send_byte(8'(i + 1), 8);
        send_byte(8'hBD, 8);
        exp_drops++;
        exp_crc++;
        @(negedge aclk);
        check("t2_crc_err_hi", crc_err, 1);
        @(negedge aclk);
        check("t2_crc_err_lo", crc_err, 0);
        check("t2_drops_lit", drop_count, 1);
        check("t2_pulses_lit", crc_pulses, 1);
`endif
        rand_payload();
        send_frame(0, 8);
        wait_drain(50, "t2");
        check_counts("t2");

        // Stall 500 cycles while seven frames arrive
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        t0 = cyc; b0 = beats; f0 = exp_frames; d0 = exp_drops;
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 16; i++) pl[i] = 8'(16 * k + i + 1);
            send_frame(0, 8);
        end
        while (cyc - t0 < 500) @(posedge aclk);
        check_counts("stall");
`ifdef FRAME_CRC_EN
        check("stall_frames_lit", frame_count, 16'(f0 + 6));
        check("stall_drops_lit", drop_count, 16'(d0 + 1));
`endif
        rdy_mode = 1;
        wait_drain(200, "stall");
        check("stall_beats", beats - b0, (exp_frames - f0) * P);
`ifdef FRAME_CRC_EN
        check("stall_beats_lit", beats - b0, 30);
`endif

        // Gap timeout: three bytes then silence
        send_byte(8'hAA, 4);
        send_byte(8'hBB, 4);
        send_byte(8'hCC, 4);
        repeat (60) @(negedge aclk);
        check("gap_no_early_drop", drop_count, exp_drops);
        repeat (10) @(negedge aclk);
        exp_drops++;
        check("gap_drop", drop_count, exp_drops);
        rand_payload();
        send_frame(0, 8);
        wait_drain(50, "gap_next");
        rand_payload();
        send_frame(0, 40);
        wait_drain(50, "gap_slow");
        check_counts("gap");

        // Random tready across 20 frames
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) begin
            rand_payload();
            send_frame(0, $urandom_range(1, 10));
        end
        rdy_mode = 1;
        wait_drain(200, "rand");
        check_counts("rand");
        check("crc_pulses_total", crc_pulses, exp_crc);

        // Reset mid-frame with two frames buffered
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        rand_payload();
        send_frame(0, 4);
        rand_payload();
        send_frame(0, 4);
        send_byte(8'h11, 4);
        send_byte(8'h22, 4);
        send_byte(8'h33, 4);
        check("prerst_tvalid", m_axis_tvalid, 1);
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("rst_async_tvalid", m_axis_tvalid, 0);
        check("rst_async_frames", frame_count, 0);
        check("rst_async_drops", drop_count, 0);
        exp_q.delete();
        exp_frames = 0;
        exp_drops  = 0;
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) pl[i] = 8'(8'hA0 + i);
        send_frame(0, 8);
        wait_drain(50, "postrst");
        check("postrst_frames_lit", frame_count, 1);
        check("postrst_drops_lit", drop_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
